// File: rtl/instr_register_pipe.sv
// instr_register_pipe
//   Instruction register file with a built-in execute stage. Each load computes
//   the result of {opcode, operand_a, operand_b} combinationally and stores the
//   whole record (plus a divide-by-zero flag) in one entry at the clock edge.
//   MODE=0 (ADDR): entries addressed by write_pointer/read_pointer.
//   MODE=1 (FIFO): internal wrap-around pointers, full/empty back-pressure.
// Ports
//   clk, reset_n                   clock, async active-low reset
//   load_en, write_pointer         write request / index (index ignored in FIFO)
//   opcode, operand_a, operand_b   instruction fields (operands signed)
//   read_en, read_pointer          read request / index (index ignored in FIFO)
//   rd_valid, rd_hit, rd_*         registered read data, held until next accepted read
//   count, full, empty             occupancy (FIFO) / written-entry count (ADDR)
//   wr_err, rd_err                 one-cycle pulses for rejected load / read
module instr_register_pipe #(
  parameter int OP_W  = 32,
  parameter int DEPTH = 32,
  parameter int MODE  = 0
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       load_en,
  input  logic [$clog2(DEPTH)-1:0]   write_pointer,
  input  logic [3:0]                 opcode,
  input  logic [OP_W-1:0]            operand_a,
  input  logic [OP_W-1:0]            operand_b,
  input  logic                       read_en,
  input  logic [$clog2(DEPTH)-1:0]   read_pointer,
  output logic                       rd_valid,
  output logic                       rd_hit,
  output logic [3:0]                 rd_opcode,
  output logic [OP_W-1:0]            rd_operand_a,
  output logic [OP_W-1:0]            rd_operand_b,
  output logic [2*OP_W-1:0]          rd_result,
  output logic                       rd_div_zero,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty,
  output logic                       wr_err,
  output logic                       rd_err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int RES_W = 2 * OP_W;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam bit FIFO = (MODE != 0);

  typedef enum logic [3:0] {
    OP_ZERO = 4'd0, OP_PASSA = 4'd1, OP_PASSB = 4'd2, OP_ADD = 4'd3,
    OP_SUB  = 4'd4, OP_MULT  = 4'd5, OP_DIV   = 4'd6, OP_MOD = 4'd7
  } op_e;

  typedef struct packed {
    logic [3:0]       op;
    logic [OP_W-1:0]  a;
    logic [OP_W-1:0]  b;
    logic [RES_W-1:0] res;
    logic             dz;
  } entry_t;

  entry_t           mem [DEPTH];
  logic [DEPTH-1:0] written;
  entry_t           ex;
  entry_t           rd_q;
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q, wr_idx, rd_idx;
  logic [CNT_W-1:0] count_q, count_nxt;
  logic             wr_acc, rd_acc;
  logic signed [RES_W-1:0] a_x, b_x;

  // ---------------- execute ----------------
  // Operands are sign-extended to RES_W so MULT keeps the full product and
  // DIV/MOD follow SystemVerilog signed semantics (truncate toward zero).
  always_comb begin
    a_x    = RES_W'($signed(operand_a));
    b_x    = RES_W'($signed(operand_b));
    ex.op  = opcode;
    ex.a   = operand_a;
    ex.b   = operand_b;
    ex.res = '0;
    ex.dz  = 1'b0;
    case (opcode)
      OP_PASSA: ex.res = a_x;
      OP_PASSB: ex.res = b_x;
      OP_ADD:   ex.res = a_x + b_x;
      OP_SUB:   ex.res = a_x - b_x;
      OP_MULT:  ex.res = a_x * b_x;
      OP_DIV:   if (b_x == '0) ex.dz = 1'b1; else ex.res = a_x / b_x;
      OP_MOD:   if (b_x == '0) ex.dz = 1'b1; else ex.res = a_x % b_x;
      default:  ex.res = '0;  // ZERO and illegal opcodes
    endcase
  end

  // ---------------- accept / index ----------------
  assign wr_idx = FIFO ? wr_ptr_q : write_pointer;
  assign rd_idx = FIFO ? rd_ptr_q : read_pointer;
  // No write-through: a read is judged against occupancy before this edge's load.
  assign rd_acc = read_en && (!FIFO || count_q != '0);
  // A full FIFO still takes a load when a read frees the oldest slot this edge.
  assign wr_acc = load_en && (!FIFO || count_q != DEPTH_C || rd_acc);

  always_comb begin
    count_nxt = count_q;
    if (FIFO) begin
      if (wr_acc && !rd_acc)      count_nxt = count_q + CNT_W'(1);
      else if (rd_acc && !wr_acc) count_nxt = count_q - CNT_W'(1);
    end else if (wr_acc && !written[wr_idx]) begin
      count_nxt = count_q + CNT_W'(1);
    end
  end

  // ---------------- storage ----------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      written <= '0;
    end else if (wr_acc) begin
      mem[wr_idx]     <= ex;
      written[wr_idx] <= 1'b1;
    end
  end

  // Pointers advance in ADDR mode too but are never selected there.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_acc) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (rd_acc) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_nxt;
    end
  end

  // ---------------- read port ----------------
  // mem is read before this edge's write lands, so same-index load+read
  // returns the old contents.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_valid <= 1'b0;
      rd_hit   <= 1'b0;
      rd_q     <= '0;
      wr_err   <= 1'b0;
      rd_err   <= 1'b0;
    end else begin
      rd_valid <= rd_acc;
      wr_err   <= load_en && !wr_acc;
      rd_err   <= read_en && !rd_acc;
      if (rd_acc) begin
        rd_q   <= mem[rd_idx];
        rd_hit <= FIFO || written[rd_idx];
      end
    end
  end

  assign rd_opcode    = rd_q.op;
  assign rd_operand_a = rd_q.a;
  assign rd_operand_b = rd_q.b;
  assign rd_result    = rd_q.res;
  assign rd_div_zero  = rd_q.dz;
  assign count        = count_q;
  assign full         = (count_q == DEPTH_C);
  assign empty        = (count_q == '0);

  a_count_max: assert property (@(posedge clk) disable iff (!reset_n) count_q <= DEPTH_C);
  a_full_empty: assert property (@(posedge clk) disable iff (!reset_n) !(full && empty));
  a_valid_err: assert property (@(posedge clk) disable iff (!reset_n) !(rd_valid && rd_err));

endmodule
